cc_line_assembler: RTL and testbench

CC_LINE_ASSEMBLER -- requirements
Module: cc_line_assembler

---
 rtl/cc_line_assembler.sv | 122 ++++++++++++
 tb/tb_cc_line_assembler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_line_assembler.sv
// cc_line_assembler
// Collects an eight-beat memory read burst into a single cache line,
// prepends a 6-bit header and writes the result to a downstream line FIFO
// as one 518-bit word.
//
// State table:
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ST_IDLE    | waiting for a line-fill request
//   ST_COLLECT | accepting memory beats into the line buffer
//   ST_PUSH    | presenting the assembled line until the FIFO takes it
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid_i       line-fill request strobe
//   req_hdr_i         header stored with the line
//   req_ready_o       high while idle, request accepted
//   mem_rdata_i       read data beat
//   mem_rvalid_i      read beat valid
//   mem_rlast_i       final beat of the burst
//   mem_rready_o      high while collecting, beat accepted
//   fifo_full_i       downstream FIFO full
//   fifo_wren_o       FIFO write strobe
//   fifo_wdata_o      {hdr, beat0 .. beat7}
//   err_o             one-cycle pulse on a burst-length mismatch
module cc_line_assembler (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid_i,
   input  logic [5:0]   req_hdr_i,
   output logic         req_ready_o,
   input  logic [63:0]  mem_rdata_i,
   input  logic         mem_rvalid_i,
   input  logic         mem_rlast_i,
   output logic         mem_rready_o,
   input  logic         fifo_full_i,
   output logic         fifo_wren_o,
   output logic [517:0] fifo_wdata_o,
   output logic         err_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PUSH    = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [5:0]     hdr_q, hdr_d;
   logic [511:0]   line_q, line_d;
   logic [2:0]     cnt_q, cnt_d;
   logic           err_q, err_d;
   logic           last_slot;

   assign last_slot = (cnt_q == 3'd7);

   always_comb begin
      state_d = state_q;
      hdr_d   = hdr_q;
      line_d  = line_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               hdr_d   = req_hdr_i;
               cnt_d   = 3'd0;
               line_d  = '0;
               state_d = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (mem_rvalid_i) begin
               // Beat k lands at [511-64k -: 64]; 511-64k == {~k, 6'h3f}.
               line_d[{~cnt_q, 6'h3f} -: 64] = mem_rdata_i;
               if (mem_rlast_i || last_slot) begin
                  state_d = ST_PUSH;
                  // Only rlast exactly on the eighth beat is a clean burst.
                  err_d   = ~(mem_rlast_i & last_slot);
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end

         ST_PUSH: begin
            if (!fifo_full_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         hdr_q   <= '0;
         line_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         line_q  <= line_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign mem_rready_o = (state_q == ST_COLLECT);
   assign fifo_wren_o  = (state_q == ST_PUSH) & ~fifo_full_i;
   assign fifo_wdata_o = {hdr_q, line_q};
   assign err_o        = err_q;

endmodule

// File: tb/tb_cc_line_assembler.sv
module tb_cc_line_assembler;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid_i;
   logic [5:0]   req_hdr_i;
   logic         req_ready_o;
   logic [63:0]  mem_rdata_i;
   logic         mem_rvalid_i;
   logic         mem_rlast_i;
   logic         mem_rready_o;
   logic         fifo_full_i;
   logic         fifo_wren_o;
   logic [517:0] fifo_wdata_o;
   logic         err_o;

   int tests = 0;
   int fails = 0;
   logic [517:0] exp_q[$];

   always #5 clk = ~clk;

   cc_line_assembler dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid_i),
      .req_hdr_i    (req_hdr_i),
      .req_ready_o  (req_ready_o),
      .mem_rdata_i  (mem_rdata_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rlast_i  (mem_rlast_i),
      .mem_rready_o (mem_rready_o),
      .fifo_full_i  (fifo_full_i),
      .fifo_wren_o  (fifo_wren_o),
      .fifo_wdata_o (fifo_wdata_o),
      .err_o        (err_o)
   );

   // Scoreboard: every FIFO write must match the oldest expected line.
   always @(negedge clk) begin
      if (fifo_wren_o) begin
         logic [517:0] exp_w;
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write got=%h required=no write", fifo_wdata_o);
         end else begin
            exp_w = exp_q.pop_front();
            if (fifo_wdata_o !== exp_w) begin
               fails++;
               $display("FAIL line_data got=%h required=%h", fifo_wdata_o, exp_w);
            end
         end
      end
   end

   task automatic run_line(input logic [5:0] hdr, input int nbeats, input bit last_final,
                           input int gap, input int full_cycles, input logic [63:0] base,
                           input bit hold_req);
      logic [517:0] exp_w;
      bit           exp_err;
      bit           extra;
      exp_w = {hdr, 512'b0};
      for (int k = 0; k < nbeats; k++) exp_w[511-64*k -: 64] = base + 64'(k);
      exp_err = !(nbeats == 8 && last_final);
      extra   = (nbeats == 8 && !last_final);

      @(posedge clk); #1;
      req_valid_i = 1'b1;
      req_hdr_i   = hdr;
      @(negedge clk);
      tests++;
      if (req_ready_o !== 1'b1) begin
         fails++; $display("FAIL req_ready_idle got=%b required=1", req_ready_o);
      end
      exp_q.push_back(exp_w);
      @(posedge clk); #1;
      req_valid_i = hold_req;
      req_hdr_i   = ~hdr;

      for (int k = 0; k < nbeats; k++) begin
         for (int g = 0; g < gap; g++) begin
            mem_rvalid_i = 1'b0;
            @(negedge clk);
            tests++;
            if (mem_rready_o !== 1'b1 || fifo_wren_o !== 1'b0) begin
               fails++;
               $display("FAIL bubble_hold rready=%b wren=%b required=1/0", mem_rready_o, fifo_wren_o);
            end
            @(posedge clk); #1;
         end
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = base + 64'(k);
         mem_rlast_i  = (k == nbeats - 1) && last_final;
         @(negedge clk);
         tests++;
         if (mem_rready_o !== 1'b1 || req_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL collect_ready beat=%0d rready=%b req_ready=%b required=1/0", k, mem_rready_o, req_ready_o);
         end
         @(posedge clk); #1;
      end

      // First PUSH cycle; a long burst keeps presenting a ninth beat here.
      req_valid_i  = 1'b0;
      mem_rvalid_i = extra;
      mem_rdata_i  = 64'hDEAD_BEEF_0000_0009;
      mem_rlast_i  = 1'b0;
      fifo_full_i  = (full_cycles > 0);
      for (int j = 0; j <= full_cycles; j++) begin
         if (j > 0) begin
            mem_rvalid_i = 1'b0;
            fifo_full_i  = (j < full_cycles);
         end
         @(negedge clk);
         tests++;
         if (fifo_wren_o !== (j == full_cycles)) begin
            fails++; $display("FAIL push_wren cyc=%0d got=%b required=%b", j, fifo_wren_o, (j == full_cycles));
         end
         tests++;
         if (fifo_wdata_o !== exp_w) begin
            fails++; $display("FAIL push_stable cyc=%0d got=%h required=%h", j, fifo_wdata_o, exp_w);
         end
         tests++;
         if (err_o !== ((j == 0) ? exp_err : 1'b0)) begin
            fails++; $display("FAIL err_pulse cyc=%0d got=%b required=%b", j, err_o, ((j == 0) ? exp_err : 1'b0));
         end
         tests++;
         if (mem_rready_o !== 1'b0 || req_ready_o !== 1'b0) begin
            fails++; $display("FAIL push_ready cyc=%0d rready=%b req_ready=%b required=0/0", j, mem_rready_o, req_ready_o);
         end
         @(posedge clk); #1;
      end

      fifo_full_i  = 1'b0;
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready_o !== 1'b1 || mem_rready_o !== 1'b0 || err_o !== 1'b0 || fifo_wren_o !== 1'b0) begin
         fails++;
         $display("FAIL back_to_idle req_ready=%b rready=%b err=%b wren=%b required=1/0/0/0", req_ready_o, mem_rready_o, err_o, fifo_wren_o);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (mem_rready_o !== 1'b0 || req_ready_o !== 1'b1) begin
         fails++; $display("FAIL req_not_queued rready=%b req_ready=%b required=0/1", mem_rready_o, req_ready_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid_i = 1'b0; req_hdr_i = '0;
      mem_rdata_i = '0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
      fifo_full_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready_o !== 1'b1 || mem_rready_o !== 1'b0 || fifo_wren_o !== 1'b0 || err_o !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl req_ready=%b rready=%b wren=%b err=%b required=1/0/0/0", req_ready_o, mem_rready_o, fifo_wren_o, err_o);
      end
      tests++;
      if (fifo_wdata_o !== 518'b0) begin
         fails++; $display("FAIL reset_data got=%h required=0", fifo_wdata_o);
      end
   endtask

   task automatic test_nominal();
      run_line(6'b010000, 8, 1'b1, 0, 0, 64'd1, 1'b0);
   endtask

   task automatic test_bubbles();
      run_line(6'b010000, 8, 1'b1, 2, 0, 64'd1, 1'b0);
   endtask

   task automatic test_backpressure();
      run_line(6'b100101, 8, 1'b1, 0, 5, 64'h1000, 1'b0);
   endtask

   task automatic test_short_burst();
      run_line(6'b001000, 3, 1'b1, 0, 0, 64'd1, 1'b0);
   endtask

   task automatic test_long_burst();
      run_line(6'b011110, 8, 1'b0, 0, 0, 64'h55, 1'b0);
   endtask

   task automatic test_ignore_req();
      run_line(6'b111111, 8, 1'b1, 1, 2, 64'hABC0, 1'b1);
   endtask

   task automatic test_back_to_back();
      run_line(6'b000011, 8, 1'b1, 0, 0, 64'h200, 1'b0);
      run_line(6'b000111, 5, 1'b1, 0, 1, 64'h300, 1'b0);
   endtask

   task automatic test_reset_mid_line();
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_hdr_i = 6'b101010;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_rvalid_i = 1'b1; mem_rdata_i = 64'hAA00 + 64'(k); mem_rlast_i = 1'b0;
         @(posedge clk); #1;
      end
      // Reset wins over a beat presented in the same cycle.
      rst = 1'b1;
      mem_rdata_i = 64'hAA04;
      @(posedge clk); #1;
      rst = 1'b0; mem_rvalid_i = 1'b0;
      @(negedge clk);
      tests++;
      if (req_ready_o !== 1'b1 || mem_rready_o !== 1'b0 || err_o !== 1'b0 || fifo_wdata_o !== 518'b0) begin
         fails++;
         $display("FAIL reset_mid req_ready=%b rready=%b err=%b data=%h required=1/0/0/0", req_ready_o, mem_rready_o, err_o, fifo_wdata_o);
      end
      run_line(6'b000001, 8, 1'b1, 0, 0, 64'd9, 1'b0);
   endtask

   task automatic test_reset_in_push();
      @(posedge clk); #1;
      req_valid_i = 1'b1; req_hdr_i = 6'b110011;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      fifo_full_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         mem_rvalid_i = 1'b1; mem_rdata_i = 64'hBB00 + 64'(k); mem_rlast_i = (k == 7);
         @(posedge clk); #1;
      end
      mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      fifo_full_i = 1'b0;
      @(negedge clk);
      tests++;
      if (fifo_wren_o !== 1'b0 || req_ready_o !== 1'b1 || fifo_wdata_o !== 518'b0) begin
         fails++;
         $display("FAIL reset_push wren=%b req_ready=%b data=%h required=0/1/0", fifo_wren_o, req_ready_o, fifo_wdata_o);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bubbles();
      test_backpressure();
      test_short_burst();
      test_long_burst();
      test_ignore_req();
      test_back_to_back();
      test_reset_mid_line();
      test_reset_in_push();
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL scoreboard_drain got=%0d pending required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
